// File: rtl/rf_sequencer.sv
// rf_sequencer: arbitrates the register-file port between the core and a
// small command engine (CLEAR range, COPY, SWAP, SUM range into accumulator).
module rf_sequencer #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [D-1:0] cmd_ra,
    input  logic [D-1:0] cmd_rb,
    output logic         done,
    output logic         err,
    input  logic [D-1:0] core_raddr,
    input  logic [D-1:0] core_waddr,
    input  logic         core_we,
    input  logic [W-1:0] core_wdata,
    output logic         core_stall,
    output logic [D-1:0] rf_raddr,
    output logic [D-1:0] rf_waddr,
    output logic         rf_write_en,
    output logic [W-1:0] rf_data_in,
    input  logic [W-1:0] rf_out_reg
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RD, S_XFER, S_WR, S_SUM, S_SUMWR, S_DONE
    } state_t;

    localparam logic [1:0]   OP_CLEAR = 2'b00;
    localparam logic [1:0]   OP_COPY  = 2'b01;
    localparam logic [1:0]   OP_SWAP  = 2'b10;
    localparam logic [1:0]   OP_SUM   = 2'b11;
    localparam logic [D-1:0] ACC_ADDR = '1;

    state_t         state_q, state_d;
    logic [D-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   tmp_q, tmp_d;
    logic [D-1:0]   ra_q, ra_d;
    logic [D-1:0]   rb_q, rb_d;
    logic [1:0]     op_q, op_d;
    logic           err_q, err_d;
    logic           we_raw;
    logic           illegal;

    // Next-state, datapath and port-mux decode; Reset gates all handshakes and writes
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tmp_d      = tmp_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        op_d       = op_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_stall = (state_q != S_IDLE);
        rf_raddr   = ptr_q;
        rf_waddr   = ptr_q;
        rf_data_in = tmp_q;
        we_raw     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The core owns the port for the whole IDLE cycle, including acceptance
                cmd_ready  = 1'b1;
                rf_raddr   = core_raddr;
                rf_waddr   = core_waddr;
                rf_data_in = core_wdata;
                we_raw     = core_we;
                case (cmd_op)
                    OP_CLEAR, OP_SUM: illegal = (cmd_ra > cmd_rb);
                    OP_COPY:          illegal = (cmd_rb == '0);
                    default:          illegal = (cmd_ra == '0) || (cmd_rb == '0);
                endcase
                if (cmd_valid && !Reset) begin
                    ra_d  = cmd_ra;
                    rb_d  = cmd_rb;
                    op_d  = cmd_op;
                    ptr_d = cmd_ra;
                    tmp_d = '0;
                    err_d = illegal;
                    if (illegal) begin
                        state_d = S_DONE;
                    end else begin
                        case (cmd_op)
                            OP_CLEAR: state_d = S_CLR;
                            OP_SUM:   state_d = S_SUM;
                            default:  state_d = S_RD;
                        endcase
                    end
                end
            end
            S_CLR: begin
                // Address 0 is walked over but never written
                rf_waddr   = ptr_q;
                rf_data_in = '0;
                we_raw     = (ptr_q != '0);
                if (ptr_q == rb_q) state_d = S_DONE;
                else               ptr_d   = ptr_q + D'(1);
            end
            S_RD: begin
                rf_raddr = ra_q;
                tmp_d    = rf_out_reg;
                state_d  = (op_q == OP_COPY) ? S_WR : S_XFER;
            end
            S_XFER: begin
                rf_raddr   = rb_q;
                rf_waddr   = ra_q;
                rf_data_in = rf_out_reg;
                we_raw     = 1'b1;
                state_d    = S_WR;
            end
            S_WR: begin
                rf_waddr   = rb_q;
                rf_data_in = tmp_q;
                we_raw     = 1'b1;
                state_d    = S_DONE;
            end
            S_SUM: begin
                // Accumulator is only written in SUMWR, so reading R15 here sees the old value
                rf_raddr = ptr_q;
                tmp_d    = tmp_q + rf_out_reg;
                if (ptr_q == rb_q) state_d = S_SUMWR;
                else               ptr_d   = ptr_q + D'(1);
            end
            S_SUMWR: begin
                rf_waddr   = ACC_ADDR;
                rf_data_in = tmp_q;
                we_raw     = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (Reset) begin
            cmd_ready  = 1'b0;
            done       = 1'b0;
            err        = 1'b0;
            core_stall = 1'b0;
        end
        rf_write_en = we_raw && !Reset;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            tmp_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tmp_q   <= tmp_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

endmodule
